// File: rtl/instr_stim_if.sv
// Handshake bundle between the instruction-stimulus generator and the exec unit.
interface instr_stim_if #(
    parameter int INSTR_W = 12,
    parameter int CNT_W   = 16
);
    logic               stall;
    logic               start;
    logic [1:0]         mode;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_word;
    logic               is_op7;
    logic [CNT_W-1:0]   instr_count;
    logic               done;

    modport master (
        input  stall, start, mode,
        output instr_valid, instr_word, is_op7, instr_count, done
    );

    modport slave (
        output stall, start, mode,
        input  instr_valid, instr_word, is_op7, instr_count, done
    );
endinterface

// File: rtl/instr_stim_gen.sv
// Instruction-stimulus generator: CLA CLL preamble, idle gap, then a seeded LFSR word stream.
// Optional STIM_SEED_LOAD_EN adds seed_load/seed_val to reseed the LFSR while idle or done.
module instr_stim_gen #(
    parameter int          INSTR_W   = 12,
    parameter int          NUM_INSTR = 10,
    parameter int          INIT_GAP  = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
`ifdef STIM_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [15:0] seed_val,
`endif
    instr_stim_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_PRE, S_GAP, S_RUN, S_DONE} state_t;

    localparam int          GAP_W    = (INIT_GAP > 1) ? $clog2(INIT_GAP) : 1;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [11:0] PRE_WORD = 12'o7300;

    state_t           state, state_nxt;
    logic [15:0]      lfsr;
    logic [1:0]       mode_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      run_cnt;
    logic [CNT_W-1:0] count_q;
    logic             done_q;

    logic             issue, accept, last_word, idle_like;
    logic [11:0]      rnd_word, word12;
    logic             rnd_op7, op7;
    logic [INSTR_W-1:0] word_full;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    endfunction

    // Opcodes 6 and 7 fold onto 0 and 1 so memory-reference words never alias IOT/operate.
    function automatic logic [11:0] mem_word(input logic [15:0] l);
        logic [2:0] op;
        op = l[15:13];
        if (op == 3'd6)      op = 3'd0;
        else if (op == 3'd7) op = 3'd1;
        return {op, l[8:0]};
    endfunction

    function automatic logic [11:0] op7_word(input logic [15:0] l);
        return {4'b1110, l[7:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign issue     = (state == S_PRE) || (state == S_RUN);
    assign accept    = issue && !bus.stall;
    assign last_word = (run_cnt == 32'(NUM_INSTR - 1));
    assign idle_like = (state == S_IDLE) || (state == S_DONE);

    always_comb begin
        rnd_word = mem_word(lfsr);
        rnd_op7  = 1'b0;
        if (mode_q == 2'd1 || (mode_q == 2'd2 && lfsr[0])) begin
            rnd_word = op7_word(lfsr);
            rnd_op7  = 1'b1;
        end
    end

    always_comb begin
        word12 = 12'd0;
        op7    = 1'b0;
        if (state == S_PRE) begin
            word12 = PRE_WORD;
            op7    = 1'b1;
        end else if (state == S_RUN) begin
            word12 = rnd_word;
            op7    = rnd_op7;
        end
        word_full        = '0;
        word_full[11:0]  = word12;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nxt = S_WAIT_RDY;
            S_WAIT_RDY:     if (!bus.stall) state_nxt = S_PRE;
            S_PRE: begin
                if (accept) begin
                    if (INIT_GAP > 0)        state_nxt = S_GAP;
                    else if (NUM_INSTR == 0) state_nxt = S_DONE;
                    else                     state_nxt = S_RUN;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(INIT_GAP - 1))
                    state_nxt = (NUM_INSTR == 0) ? S_DONE : S_RUN;
            end
            S_RUN:          if (accept && last_word) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            lfsr    <= SEED;
            mode_q  <= 2'd0;
            gap_cnt <= '0;
            run_cnt <= 32'd0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (idle_like && bus.start) begin
                mode_q  <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;
                run_cnt <= 32'd0;
                count_q <= '0;
                done_q  <= 1'b0;
            end
`ifdef STIM_SEED_LOAD_EN
            // A zero seed would lock the LFSR, so it falls back to the default.
            if (idle_like && seed_load)
                lfsr <= (seed_val == 16'd0) ? SEED : seed_val;
`endif
            if (state == S_PRE)      gap_cnt <= '0;
            else if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            if (state == S_RUN && accept) begin
                lfsr    <= lfsr_step(lfsr);
                run_cnt <= run_cnt + 32'd1;
                count_q <= sat_inc(count_q);
            end
            if (state_nxt == S_DONE) done_q <= 1'b1;
        end
    end

    assign bus.instr_valid = issue;
    assign bus.instr_word  = word_full;
    assign bus.is_op7      = op7;
    assign bus.instr_count = count_q;
    assign bus.done        = done_q;
endmodule
